// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg
// Shared types for the vector permutation path: widths, the permutation op
// and osize encodings, the sequencer state type, and the osize decoder used
// to build the ALU control vectors and the writeback byte enables.
package riscv_v_pkg;

  localparam int RISCV_DATA_WIDTH         = 32;
  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_VALID_OSIZES = 4;
  localparam int RISCV_V_BE_WIDTH         = RISCV_V_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    PERM_NOP = 2'd0,
    PERM_I2V = 2'd1,
    PERM_V2I = 2'd2,
    PERM_RSV = 2'd3
  } riscv_v_perm_op_e;

  typedef enum logic [1:0] {
    OSIZE_BYTE  = 2'd0,
    OSIZE_HALF  = 2'd1,
    OSIZE_WORD  = 2'd2,
    OSIZE_DWORD = 2'd3
  } riscv_v_osize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } riscv_v_perm_state_e;

  typedef struct packed {
    logic [RISCV_V_NUM_VALID_OSIZES-1:0] onehot;
    logic [RISCV_V_NUM_VALID_OSIZES-1:0] therm;
    logic [RISCV_V_BE_WIDTH-1:0]         byte_en;
  } riscv_v_osize_dec_t;

  // onehot: bit osize set; therm: bit i set when osize >= i;
  // byte_en: low 2**osize byte lanes set.
  function automatic riscv_v_osize_dec_t riscv_v_osize_decode(input riscv_v_osize_e osize);
    riscv_v_osize_dec_t d;
    d.onehot  = '0;
    d.therm   = '0;
    d.byte_en = '0;
    for (int i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
      d.onehot[i] = (int'(osize) == i);
      d.therm[i]  = (int'(osize) >= i);
    end
    case (osize)
      OSIZE_BYTE:  d.byte_en = 16'h0001;
      OSIZE_HALF:  d.byte_en = 16'h0003;
      OSIZE_WORD:  d.byte_en = 16'h000F;
      default:     d.byte_en = 16'h00FF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_v_permutation_ALU.sv
// riscv_v_permutation_ALU
// Combinational move unit shared by vector permutation sequencers.
//   i_is_i2v / i_is_v2i      op selects (outputs are zero when neither is set)
//   i_srca                   zero-extended scalar operand
//   i_srcb                   vector element-0 slice
//   i_osize_vector           one-hot element size
//   i_osize_greater_vector   thermometer element size (bit i = osize >= i)
//   o_int_result             V2I: element 0 of i_srcb sign-extended to XLEN
//   o_vec_result             I2V: i_srcb with element 0 replaced by i_srca
module riscv_v_permutation_ALU
  import riscv_v_pkg::*;
(
  input  logic                                i_is_i2v,
  input  logic                                i_is_v2i,
  input  logic [RISCV_V_DATA_WIDTH-1:0]       i_srca,
  input  logic [RISCV_V_DATA_WIDTH-1:0]       i_srcb,
  input  logic [RISCV_V_NUM_VALID_OSIZES-1:0] i_osize_vector,
  input  logic [RISCV_V_NUM_VALID_OSIZES-1:0] i_osize_greater_vector,
  output logic [RISCV_DATA_WIDTH-1:0]         o_int_result,
  output logic [RISCV_V_DATA_WIDTH-1:0]       o_vec_result
);

  logic [RISCV_V_DATA_WIDTH-1:0] w_elem_mask;

  // Element 0 spans bytes 0, 0-1, 0-3 or 0-7; the thermometer vector maps
  // straight onto those lane groups.
  always_comb begin
    w_elem_mask         = '0;
    w_elem_mask[7:0]    = {8{i_osize_greater_vector[0]}};
    w_elem_mask[15:8]   = {8{i_osize_greater_vector[1]}};
    w_elem_mask[31:16]  = {16{i_osize_greater_vector[2]}};
    w_elem_mask[63:32]  = {32{i_osize_greater_vector[3]}};
  end

  always_comb begin
    o_vec_result = '0;
    if (i_is_i2v) begin
      o_vec_result = (i_srca & w_elem_mask) | (i_srcb & ~w_elem_mask);
    end
  end

  // A 64-bit element cannot fit XLEN=32, so DWORD (and WORD) pass the low
  // 32 bits through untouched.
  always_comb begin
    o_int_result = '0;
    if (i_is_v2i) begin
      case (i_osize_vector)
        4'b0001: o_int_result = {{24{i_srcb[7]}},  i_srcb[7:0]};
        4'b0010: o_int_result = {{16{i_srcb[15]}}, i_srcb[15:0]};
        default: o_int_result = i_srcb[RISCV_DATA_WIDTH-1:0];
      endcase
    end
  end

endmodule

// File: rtl/riscv_v_permutation_ctrl.sv
// riscv_v_permutation_ctrl
// Sequencer between vector issue, the external permutation ALU and the
// scalar / vector register-file writeback ports.
//   clk, rst_n, flush              clock, async active-low reset, sync kill
//   req_*                          issue request (valid/ready handshake)
//   alu_*                          drive to / results from the permutation ALU
//   int_wb_*                       scalar writeback (V2I results)
//   vec_wb_*                       vector writeback (I2V results)
//   busy, perm_done_cnt            status
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; NOP / reserved ops are dropped here
// EXEC    | ALU driven from operand registers, result captured
// RESP    | result held on the selected writeback port until ready
module riscv_v_permutation_ctrl
  import riscv_v_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [1:0]                          req_op,
  input  logic [1:0]                          req_osize,
  input  logic [4:0]                          req_dst,
  input  logic [RISCV_DATA_WIDTH-1:0]         req_scalar,
  input  logic [RISCV_V_DATA_WIDTH-1:0]       req_vec,
  output logic                                alu_is_i2v,
  output logic                                alu_is_v2i,
  output logic [RISCV_V_DATA_WIDTH-1:0]       alu_srca,
  output logic [RISCV_V_DATA_WIDTH-1:0]       alu_srcb,
  output logic [RISCV_V_NUM_VALID_OSIZES-1:0] alu_osize_vector,
  output logic [RISCV_V_NUM_VALID_OSIZES-1:0] alu_osize_greater_vector,
  input  logic [RISCV_DATA_WIDTH-1:0]         alu_int_result,
  input  logic [RISCV_V_DATA_WIDTH-1:0]       alu_vec_result,
  output logic                                int_wb_valid,
  input  logic                                int_wb_ready,
  output logic [RISCV_DATA_WIDTH-1:0]         int_wb_data,
  output logic [4:0]                          int_wb_rd,
  output logic                                vec_wb_valid,
  input  logic                                vec_wb_ready,
  output logic [RISCV_V_DATA_WIDTH-1:0]       vec_wb_data,
  output logic [4:0]                          vec_wb_vd,
  output logic [RISCV_V_BE_WIDTH-1:0]         vec_wb_byte_en,
  output logic                                busy,
  output logic [15:0]                         perm_done_cnt
);

  riscv_v_perm_state_e r_state, w_state_nxt;

  riscv_v_perm_op_e                    r_op;
  logic [4:0]                          r_dst;
  logic [RISCV_DATA_WIDTH-1:0]         r_srca;
  logic [RISCV_V_DATA_WIDTH-1:0]       r_srcb;
  logic [RISCV_V_NUM_VALID_OSIZES-1:0] r_osize_vec;
  logic [RISCV_V_NUM_VALID_OSIZES-1:0] r_osize_gt_vec;
  logic [RISCV_V_BE_WIDTH-1:0]         r_byte_en;
  logic [RISCV_DATA_WIDTH-1:0]         r_int_res;
  logic [RISCV_V_DATA_WIDTH-1:0]       r_vec_res;
  logic [15:0]                         r_cnt;

  logic               w_fire;
  logic               w_start;
  riscv_v_osize_dec_t w_dec;

  assign w_dec = riscv_v_osize_decode(riscv_v_osize_e'(req_osize));

  always_comb begin
    w_fire      = 1'b0;
    w_start     = 1'b0;
    req_ready   = 1'b0;
    w_state_nxt = r_state;

    if (r_state == ST_RESP) begin
      w_fire = (r_op == PERM_V2I) ? int_wb_ready : vec_wb_ready;
    end
    req_ready = (r_state == ST_IDLE) | w_fire;
    // Only real ops leave IDLE; NOP and reserved are consumed and dropped.
    w_start   = req_valid & req_ready & ~flush &
                ((req_op == PERM_I2V) | (req_op == PERM_V2I));

    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (w_fire) w_state_nxt = w_start ? ST_EXEC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= PERM_NOP;
      r_dst          <= '0;
      r_srca         <= '0;
      r_srcb         <= '0;
      r_osize_vec    <= '0;
      r_osize_gt_vec <= '0;
      r_byte_en      <= '0;
      r_int_res      <= '0;
      r_vec_res      <= '0;
      r_cnt          <= '0;
    end else begin
      // Osize vectors only change on acceptance, so they hold outside EXEC.
      if (w_start) begin
        r_op           <= riscv_v_perm_op_e'(req_op);
        r_dst          <= req_dst;
        r_srca         <= req_scalar;
        r_srcb         <= req_vec;
        r_osize_vec    <= w_dec.onehot;
        r_osize_gt_vec <= w_dec.therm;
        r_byte_en      <= w_dec.byte_en;
      end
      if ((r_state == ST_EXEC) && !flush) begin
        r_int_res <= alu_int_result;
        r_vec_res <= alu_vec_result;
      end
      if (w_fire && !flush) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign alu_is_i2v               = (r_state == ST_EXEC) & (r_op == PERM_I2V);
  assign alu_is_v2i               = (r_state == ST_EXEC) & (r_op == PERM_V2I);
  assign alu_srca                 = {{(RISCV_V_DATA_WIDTH-RISCV_DATA_WIDTH){1'b0}}, r_srca};
  assign alu_srcb                 = r_srcb;
  assign alu_osize_vector         = r_osize_vec;
  assign alu_osize_greater_vector = r_osize_gt_vec;

  assign int_wb_valid   = (r_state == ST_RESP) & (r_op == PERM_V2I);
  assign int_wb_data    = r_int_res;
  assign int_wb_rd      = r_dst;
  assign vec_wb_valid   = (r_state == ST_RESP) & (r_op == PERM_I2V);
  assign vec_wb_data    = r_vec_res;
  assign vec_wb_vd      = r_dst;
  assign vec_wb_byte_en = r_byte_en;

  assign busy          = (r_state != ST_IDLE);
  assign perm_done_cnt = r_cnt;

endmodule

// File: tb/tb_riscv_v_permutation_ctrl.sv
module tb_riscv_v_permutation_ctrl;
  import riscv_v_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [1:0]   req_osize = 2'd0;
  logic [4:0]   req_dst = 5'd0;
  logic [31:0]  req_scalar = 32'd0;
  logic [127:0] req_vec = 128'd0;
  logic         alu_is_i2v, alu_is_v2i;
  logic [127:0] alu_srca, alu_srcb;
  logic [3:0]   alu_osize_vector, alu_osize_greater_vector;
  logic [31:0]  alu_int_result;
  logic [127:0] alu_vec_result;
  logic         int_wb_valid;
  logic         int_wb_ready = 1'b1;
  logic [31:0]  int_wb_data;
  logic [4:0]   int_wb_rd;
  logic         vec_wb_valid;
  logic         vec_wb_ready = 1'b1;
  logic [127:0] vec_wb_data;
  logic [4:0]   vec_wb_vd;
  logic [15:0]  vec_wb_byte_en;
  logic         busy;
  logic [15:0]  perm_done_cnt;

  always #5 clk = ~clk;

  riscv_v_permutation_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_osize(req_osize), .req_dst(req_dst), .req_scalar(req_scalar),
    .req_vec(req_vec),
    .alu_is_i2v(alu_is_i2v), .alu_is_v2i(alu_is_v2i),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_osize_vector(alu_osize_vector),
    .alu_osize_greater_vector(alu_osize_greater_vector),
    .alu_int_result(alu_int_result), .alu_vec_result(alu_vec_result),
    .int_wb_valid(int_wb_valid), .int_wb_ready(int_wb_ready),
    .int_wb_data(int_wb_data), .int_wb_rd(int_wb_rd),
    .vec_wb_valid(vec_wb_valid), .vec_wb_ready(vec_wb_ready),
    .vec_wb_data(vec_wb_data), .vec_wb_vd(vec_wb_vd),
    .vec_wb_byte_en(vec_wb_byte_en),
    .busy(busy), .perm_done_cnt(perm_done_cnt)
  );

  riscv_v_permutation_ALU alu (
    .i_is_i2v(alu_is_i2v), .i_is_v2i(alu_is_v2i),
    .i_srca(alu_srca), .i_srcb(alu_srcb),
    .i_osize_vector(alu_osize_vector),
    .i_osize_greater_vector(alu_osize_greater_vector),
    .o_int_result(alu_int_result), .o_vec_result(alu_vec_result)
  );

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   osize;
    logic [4:0]   dst;
    logic [31:0]  scalar;
    logic [127:0] vec;
    logic [31:0]  exp_int;
    logic [127:0] exp_vec;
    logic [3:0]   exp_oh;
    logic [3:0]   exp_th;
    logic [15:0]  exp_be;
  } vec_t;

  vec_t        tbl [10];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  localparam logic [127:0] VBG = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] be_mask(input logic [15:0] be);
    logic [127:0] m;
    m = '0;
    for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Full request -> EXEC -> RESP -> IDLE walk with both writeback readies high.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_osize = v.osize; req_dst = v.dst;
    req_scalar = v.scalar; req_vec = v.vec;
    #1 chk("ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("exec_busy", busy, 1'b1);
    chk("exec_rdy", req_ready, 1'b0);
    chk("exec_i2v", alu_is_i2v, v.op == 2'd1);
    chk("exec_v2i", alu_is_v2i, v.op == 2'd2);
    chk("exec_oh", alu_osize_vector, v.exp_oh);
    chk("exec_th", alu_osize_greater_vector, v.exp_th);
    chk("exec_ivld", int_wb_valid, 1'b0);
    chk("exec_vvld", vec_wb_valid, 1'b0);
    @(negedge clk);
    chk("resp_is", {alu_is_i2v, alu_is_v2i}, 2'b00);
    chk("resp_oh_hold", alu_osize_vector, v.exp_oh);
    if (v.op == 2'd2) begin
      chk("v2i_ivld", int_wb_valid, 1'b1);
      chk("v2i_vvld", vec_wb_valid, 1'b0);
      chk("v2i_data", int_wb_data, v.exp_int);
      chk("v2i_rd", int_wb_rd, v.dst);
    end else begin
      chk("i2v_vvld", vec_wb_valid, 1'b1);
      chk("i2v_ivld", int_wb_valid, 1'b0);
      chk("i2v_data", vec_wb_data & be_mask(v.exp_be), v.exp_vec);
      chk("i2v_vd", vec_wb_vd, v.dst);
      chk("i2v_be", vec_wb_byte_en, v.exp_be);
    end
    exp_cnt++;
    @(negedge clk);
    chk("done_cnt", perm_done_cnt, exp_cnt);
    chk("done_idle", busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{2'd1, 2'd1, 5'd3,  32'hDEADBEEF, VBG, 32'h0, 128'hBEEF,             4'b0010, 4'b0011, 16'h0003};
    tbl[1] = '{2'd1, 2'd0, 5'd1,  32'h12345678, VBG, 32'h0, 128'h78,               4'b0001, 4'b0001, 16'h0001};
    tbl[2] = '{2'd1, 2'd2, 5'd31, 32'hCAFEF00D, VBG, 32'h0, 128'hCAFEF00D,         4'b0100, 4'b0111, 16'h000F};
    tbl[3] = '{2'd1, 2'd3, 5'd0,  32'h89ABCDEF, VBG, 32'h0, 128'h0000000089ABCDEF, 4'b1000, 4'b1111, 16'h00FF};
    tbl[4] = '{2'd2, 2'd0, 5'd7,  32'h0, {64'h0123456789ABCDEF, 64'h7654321012345680}, 32'hFFFFFF80, 128'h0, 4'b0001, 4'b0001, 16'h0};
    tbl[5] = '{2'd2, 2'd0, 5'd2,  32'h0, {64'h0123456789ABCDEF, 64'h765432101234567F}, 32'h0000007F, 128'h0, 4'b0001, 4'b0001, 16'h0};
    tbl[6] = '{2'd2, 2'd1, 5'd9,  32'h0, {64'h0123456789ABCDEF, 64'h7654321012348001}, 32'hFFFF8001, 128'h0, 4'b0010, 4'b0011, 16'h0};
    tbl[7] = '{2'd2, 2'd1, 5'd10, 32'h0, {64'h0123456789ABCDEF, 64'h7654321012347FFF}, 32'h00007FFF, 128'h0, 4'b0010, 4'b0011, 16'h0};
    tbl[8] = '{2'd2, 2'd2, 5'd30, 32'h0, {64'h0123456789ABCDEF, 64'h7654321080000001}, 32'h80000001, 128'h0, 4'b0100, 4'b0111, 16'h0};
    tbl[9] = '{2'd2, 2'd3, 5'd15, 32'h0, {64'h0123456789ABCDEF, 64'h76543210FEDCBA98}, 32'hFEDCBA98, 128'h0, 4'b1000, 4'b1111, 16'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", perm_done_cnt, 16'd0);
    chk("rst_vld", {int_wb_valid, vec_wb_valid}, 2'b00);
    chk("rst_is", {alu_is_i2v, alu_is_v2i}, 2'b00);
    chk("rst_oh", alu_osize_vector, 4'b0000);
    chk("rst_th", alu_osize_greater_vector, 4'b0000);
    chk("rst_data", {int_wb_data, vec_wb_data}, 160'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Writeback stall with back-to-back request on the fire cycle
    int_wb_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_osize = 2'd2; req_dst = 5'd12;
    req_vec = {64'h0, 64'hAAAAAAAA13579BDF};
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_vld", int_wb_valid, 1'b1);
      chk("stall_data", int_wb_data, 32'h13579BDF);
      chk("stall_rd", int_wb_rd, 5'd12);
      chk("stall_rdy", req_ready, 1'b0);
      chk("stall_cnt", perm_done_cnt, exp_cnt);
      chk("stall_oh", alu_osize_vector, 4'b0100);
      @(negedge clk);
    end
    int_wb_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'd1; req_osize = 2'd0; req_dst = 5'd4;
    req_scalar = 32'h000000AB; req_vec = VBG;
    #1 chk("fire_rdy", req_ready, 1'b1);
    exp_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_exec", alu_is_i2v, 1'b1);
    chk("b2b_cnt", perm_done_cnt, exp_cnt);
    chk("b2b_ivld", int_wb_valid, 1'b0);
    chk("b2b_oh", alu_osize_vector, 4'b0001);
    @(negedge clk);
    chk("b2b_vvld", vec_wb_valid, 1'b1);
    chk("b2b_data", vec_wb_data[7:0], 8'hAB);
    chk("b2b_vd", vec_wb_vd, 5'd4);
    exp_cnt++;
    @(negedge clk);
    chk("b2b_done", perm_done_cnt, exp_cnt);

    // Flush during EXEC
    req_valid = 1'b1; req_op = 2'd1; req_osize = 2'd1; req_dst = 5'd5; req_scalar = 32'h1111;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_exec_busy", busy, 1'b0);
    chk("fl_exec_rdy", req_ready, 1'b1);
    chk("fl_exec_vld", {int_wb_valid, vec_wb_valid}, 2'b00);
    @(negedge clk);
    chk("fl_exec_vld2", {int_wb_valid, vec_wb_valid}, 2'b00);
    chk("fl_exec_cnt", perm_done_cnt, exp_cnt);

    // Flush during RESP overrides a fire and a same-cycle request
    req_valid = 1'b1; req_op = 2'd2; req_osize = 2'd0; req_vec = 128'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("fl_resp_vld", int_wb_valid, 1'b1);
    flush = 1'b1; req_valid = 1'b1; req_op = 2'd1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_resp_busy", busy, 1'b0);
    chk("fl_resp_rdy", req_ready, 1'b1);
    chk("fl_resp_vld2", {int_wb_valid, vec_wb_valid}, 2'b00);
    chk("fl_resp_cnt", perm_done_cnt, exp_cnt);

    // NOP and reserved ops are consumed and dropped
    req_valid = 1'b1; req_op = 2'd0;
    #1 chk("nop_rdy", req_ready, 1'b1);
    @(negedge clk);
    chk("nop_busy", busy, 1'b0);
    chk("nop_vld", {int_wb_valid, vec_wb_valid}, 2'b00);
    req_op = 2'd3;
    #1 chk("rsv_rdy", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsv_busy", busy, 1'b0);
    chk("rsv_vld", {int_wb_valid, vec_wb_valid}, 2'b00);
    @(negedge clk);
    chk("rsv_cnt", perm_done_cnt, exp_cnt);

    // Asynchronous reset while a result is stalled in RESP
    vec_wb_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_osize = 2'd2; req_dst = 5'd8; req_scalar = 32'h42;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_vld", vec_wb_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vec_wb_valid, 1'b0);
    chk("arst_cnt", perm_done_cnt, 16'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_oh", alu_osize_vector, 4'b0000);
    exp_cnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    vec_wb_ready = 1'b1;
    run_op(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
